// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter and its load queue.
package wb_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_lq_fifo.sv
// Load-return queue: FIFO with wrap-around read/write pointers plus an occupancy count.
module wb_lq_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results take priority over queued load returns; tracks pending loads in busy.
// Optional WB_BYPASS_EN adds a same-cycle forwarding port for the decode stage.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wa,
    input  logic [DW-1:0] alu_wd,
    // lsu handshake: a load transfers at posedge when lsu_valid && lsu_ready;
    // lsu_valid and its payload must hold until that edge, lsu_ready never depends on lsu_valid.
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_wa,
    input  logic [DW-1:0] lsu_wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    output logic [31:0]   busy,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0] byp_ra1,
    input  logic [AW-1:0] byp_ra2,
    output logic          byp_hit1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_d1,
    output logic [DW-1:0] byp_d2,
`endif
    output logic          reg_we,
    output logic [AW-1:0] reg_wa,
    output logic [DW-1:0] reg_wd
);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    wb_req_t       lq_head;
    wb_req_t       lq_in;
    logic [CW-1:0] lq_count;
    logic          lq_full;
    logic          lq_empty;
    logic          lq_push;
    logic          lq_pop;
    logic          alu_win;
    logic          lq_win;
    logic          wr_is_load;
    logic [31:0]   busy_next;

    assign lq_in     = '{wa: lsu_wa, wd: lsu_wd};
    assign lsu_ready = !lq_full;
    assign lq_push   = lsu_valid && lsu_ready;

    wb_lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data (lq_in),
        .pop       (lq_pop),
        .head      (lq_head),
        .count     (lq_count),
        .full      (lq_full),
        .empty     (lq_empty)
    );

    // Zero-destination entries drain even while the ALU owns the port.
    always_comb begin
        alu_win = alu_valid && (alu_wa != REG_ZERO);
        lq_win  = !alu_win && !lq_empty && (lq_head.wa != REG_ZERO);
        lq_pop  = !lq_empty && ((lq_head.wa == REG_ZERO) || !alu_win);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we     <= 1'b0;
            reg_wa     <= '0;
            reg_wd     <= '0;
            wr_is_load <= 1'b0;
        end else begin
            reg_we     <= alu_win || lq_win;
            wr_is_load <= lq_win;
            if (alu_win) begin
                reg_wa <= alu_wa;
                reg_wd <= alu_wd;
            end else if (lq_win) begin
                reg_wa <= lq_head.wa;
                reg_wd <= lq_head.wd;
            end
        end
    end

    // Clear first so that a same-cycle issue to the same register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (reg_we && wr_is_load) busy_next[reg_wa] = 1'b0;
        if (iss_valid && (iss_wa != REG_ZERO)) busy_next[iss_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        byp_hit1 = reg_we && (reg_wa == byp_ra1) && (byp_ra1 != REG_ZERO);
        byp_hit2 = reg_we && (reg_wa == byp_ra2) && (byp_ra2 != REG_ZERO);
        byp_d1   = byp_hit1 ? reg_wd : '0;
        byp_d2   = byp_hit2 ? reg_wd : '0;
    end
`endif

    logic unused_count;
    assign unused_count = ^lq_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (bypass checks compiled in with WB_BYPASS_EN).
module tb_wb_arbiter;
    import wb_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_wa = '0;
    logic [DW-1:0] alu_wd = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_wa = '0;
    logic [DW-1:0] lsu_wd = '0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_wa = '0;
    logic [31:0]   busy;
    logic          reg_we;
    logic [AW-1:0] reg_wa;
    logic [DW-1:0] reg_wd;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_ra1 = '0;
    logic [AW-1:0] byp_ra2 = '0;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [DW-1:0] byp_d1;
    logic [DW-1:0] byp_d2;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter #(.LQ_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_wa    (lsu_wa),
        .lsu_wd    (lsu_wd),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .busy      (busy),
`ifdef WB_BYPASS_EN
        .byp_ra1   (byp_ra1),
        .byp_ra2   (byp_ra2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_d1    (byp_d1),
        .byp_d2    (byp_d2),
`endif
        .reg_we    (reg_we),
        .reg_wa    (reg_wa),
        .reg_wd    (reg_wd)
    );

    // Advance to 1ns after the next rising edge; inputs set before this are sampled at that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        alu_wa = '0; alu_wd = '0; lsu_wa = '0; lsu_wd = '0; iss_wa = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", reg_we); end
        checks++; if (reg_wa !== 5'd0) begin errors++; $display("FAIL reset_wa got %0d want 0", reg_wa); end
        checks++; if (reg_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", reg_wd); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", lsu_ready); end

        // Fill the queue behind ALU traffic, then reset asynchronously mid-cycle.
        iss_valid = 1'b1; iss_wa = 5'd5;
        alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 32'h1;
        lsu_valid = 1'b1; lsu_wa = 5'd10; lsu_wd = 32'h10;
        step();
        iss_valid = 1'b0;
        alu_wa = 5'd2; alu_wd = 32'h2;
        lsu_wa = 5'd11; lsu_wd = 32'h11;
        step();
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL midrst_full got %b want 0", lsu_ready); end
        checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL midrst_busy5 got %b want 1", busy[5]); end
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd2) begin errors++; $display("FAIL midrst_alu we %b wa %0d want 1/2", reg_we, reg_wa); end
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL midrst_we got %b want 0", reg_we); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL midrst_busy got %h want 0", busy); end
        step();
        rst = 1'b0;
        step();
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", lsu_ready); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL midrst_flushed got we %b want 0", reg_we); end
    endtask

    task automatic test_lone_load();
        idle_inputs();
        iss_valid = 1'b1; iss_wa = 5'd7;
        step();
        iss_valid = 1'b0;
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL lone_busy_set got %b want 1", busy[7]); end
        step(); step();
        lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'hDEADBEEF;
        step();
        lsu_valid = 1'b0;
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL lone_t4_we got %b want 0", reg_we); end
        step();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd7 || reg_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lone_write we %b wa %0d wd %h want 1/7/deadbeef", reg_we, reg_wa, reg_wd); end
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL lone_busy_t5 got %b want 1", busy[7]); end
        step();
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL lone_busy_clr got %h want 0", busy); end
        checks++; if (reg_we !== 1'b0 || reg_wa !== 5'd7 || reg_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lone_hold we %b wa %0d wd %h want 0/7/deadbeef", reg_we, reg_wa, reg_wd); end
    endtask

    task automatic test_conflict();
        idle_inputs();
        alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'h11;
        lsu_valid = 1'b1; lsu_wa = 5'd4; lsu_wd = 32'h22;
        step();
        idle_inputs();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd3 || reg_wd !== 32'h11) begin
            errors++; $display("FAIL conflict_alu we %b wa %0d wd %h want 1/3/11", reg_we, reg_wa, reg_wd); end
        step();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd4 || reg_wd !== 32'h22) begin
            errors++; $display("FAIL conflict_load we %b wa %0d wd %h want 1/4/22", reg_we, reg_wa, reg_wd); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL conflict_idle got we %b want 0", reg_we); end
    endtask

    task automatic test_full_queue();
        logic [AW-1:0] lwa [3];
        logic [DW-1:0] lwd [3];
        logic          exp_ready [4];
        logic [AW+DW-1:0] exp;
        int ld_idx;
        lwa[0] = 5'd20; lwd[0] = 32'hA0;
        lwa[1] = 5'd21; lwd[1] = 32'hA1;
        lwa[2] = 5'd22; lwd[2] = 32'hA2;
        exp_ready[0] = 1'b1; exp_ready[1] = 1'b1; exp_ready[2] = 1'b0; exp_ready[3] = 1'b0;
        ld_idx = 0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_wa = AW'(i + 1); alu_wd = 32'h100 + i;
            lsu_valid = 1'b1; lsu_wa = lwa[ld_idx]; lsu_wd = lwd[ld_idx];
            checks++; if (lsu_ready !== exp_ready[i]) begin errors++; $display("FAIL full_ready%0d got %b want %b", i, lsu_ready, exp_ready[i]); end
            if (lsu_ready === 1'b1) begin exp_q.push_back({lwa[ld_idx], lwd[ld_idx]}); ld_idx++; end
            step();
            checks++; if (reg_we !== 1'b1 || reg_wa !== AW'(i + 1) || reg_wd !== 32'h100 + i) begin
                errors++; $display("FAIL full_alu%0d we %b wa %0d wd %h", i, reg_we, reg_wa, reg_wd); end
        end
        alu_valid = 1'b0;
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL full_no_lookahead got %b want 0", lsu_ready); end
        for (int c = 0; c < 12; c++) begin
            if (ld_idx < 3) begin
                lsu_valid = 1'b1; lsu_wa = lwa[ld_idx]; lsu_wd = lwd[ld_idx];
            end else begin
                lsu_valid = 1'b0;
            end
            if (lsu_valid && lsu_ready === 1'b1) begin exp_q.push_back({lwa[ld_idx], lwd[ld_idx]}); ld_idx++; end
            step();
            if (reg_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL full_drain_extra wa %0d wd %h want none", reg_wa, reg_wd);
                end else begin
                    exp = exp_q.pop_front();
                    if ({reg_wa, reg_wd} !== exp) begin
                        errors++; $display("FAIL full_drain_order got %0d/%h want %0d/%h", reg_wa, reg_wd, exp[AW+DW-1:DW], exp[DW-1:0]);
                    end
                end
            end
        end
        checks++; if (ld_idx != 3) begin errors++; $display("FAIL full_accepts got %0d want 3", ld_idx); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_lost got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hFF;
        lsu_valid = 1'b1; lsu_wa = 5'd0; lsu_wd = 32'hAA;
        iss_valid = 1'b1; iss_wa = 5'd0;
        step();
        idle_inputs();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL zero_alu_we got %b want 0", reg_we); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL zero_busy got %h want 0", busy); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL zero_load_we got %b want 0", reg_we); end
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL zero_drained got %b want 1", lsu_ready); end
        // A zero entry at the head must drain while the ALU wins, so r8 follows immediately.
        lsu_valid = 1'b1; lsu_wa = 5'd0; lsu_wd = 32'hAA;
        step();
        alu_valid = 1'b1; alu_wa = 5'd6; alu_wd = 32'h66;
        lsu_wa = 5'd8; lsu_wd = 32'h88;
        step();
        idle_inputs();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd6 || reg_wd !== 32'h66) begin
            errors++; $display("FAIL zero_alu6 we %b wa %0d wd %h want 1/6/66", reg_we, reg_wa, reg_wd); end
        step();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd8 || reg_wd !== 32'h88) begin
            errors++; $display("FAIL zero_silent_pop we %b wa %0d wd %h want 1/8/88", reg_we, reg_wa, reg_wd); end
        step();
    endtask

    task automatic test_collision();
        idle_inputs();
        iss_valid = 1'b1; iss_wa = 5'd9;
        step();
        idle_inputs();
        lsu_valid = 1'b1; lsu_wa = 5'd9; lsu_wd = 32'h99;
        step();
        idle_inputs();
        step();
        checks++; if (reg_we !== 1'b1 || reg_wa !== 5'd9 || reg_wd !== 32'h99) begin
            errors++; $display("FAIL coll_write we %b wa %0d wd %h want 1/9/99", reg_we, reg_wa, reg_wd); end
        iss_valid = 1'b1; iss_wa = 5'd9;
`ifdef WB_BYPASS_EN
        byp_ra1 = 5'd9; byp_ra2 = 5'd3;
        #1;
        checks++; if (byp_hit1 !== 1'b1 || byp_d1 !== 32'h99) begin errors++; $display("FAIL byp1 hit %b d %h want 1/99", byp_hit1, byp_d1); end
        checks++; if (byp_hit2 !== 1'b0 || byp_d2 !== 32'h0) begin errors++; $display("FAIL byp2 hit %b d %h want 0/0", byp_hit2, byp_d2); end
        byp_ra1 = 5'd0; byp_ra2 = 5'd0;
`endif
        step();
        idle_inputs();
        checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL coll_busy9 got %b want 1", busy[9]); end
        step();
        checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL coll_busy9_hold got %b want 1", busy[9]); end
    endtask

    initial begin
        test_reset();
        test_lone_load();
        test_conflict();
        test_full_queue();
        test_zero_reg();
        test_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back arbiter sitting in front of the 32x32 register file write port (reg_we/reg_wa/reg_wd). It merges single-cycle ALU results and variable-latency load returns into the one write port. It buffers loads that lose arbitration and keeps a pending-write scoreboard so the issue stage can stall on RAW hazards against outstanding loads. Register 0 is hardwired zero: it is never written and never marked busy.

Parameters:
LQ_DEPTH, 2, load-return queue entries (power of two, >=2)
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result valid this cycle (no backpressure)
alu_wa  in  AW  ALU destination register
alu_wd  in  DW  ALU result
lsu_valid  in  1  load return valid
lsu_ready  out  1  arbiter can accept a load return
lsu_wa  in  AW  load destination register
lsu_wd  in  DW  load data
iss_valid  in  1  load issued this cycle; mark destination pending
iss_wa  in  AW  destination of issued load
busy  out  32  per-register pending-load bits; bit 0 always 0
reg_we  out  1  to regfile write enable
reg_wa  out  AW  to regfile write address
reg_wd  out  DW  to regfile write data

Behaviour:
- Reset (async, rst=1): queue empty; reg_we=0, reg_wa=0, reg_wd=0; busy=0; lsu_ready=1 one cycle after rst deasserts (combinational from queue not full).
- Load accept: handshake on lsu_valid && lsu_ready at posedge; entry pushed into queue (FIFO order, wrap-around pointers plus count).
- lsu_ready = (count < LQ_DEPTH). It does not look ahead to a same-cycle pop.
- Arbitration per cycle: ALU has absolute priority. If alu_valid && alu_wa!=0, ALU is the winner. Otherwise, if the queue is non-empty and its head wa!=0, the head is popped and is the winner.
- Entries with wa==0 are popped silently with no write, even in a cycle where the ALU wins.
- Write stage is registered: the winner appears on reg_we/reg_wa/reg_wd exactly one cycle after arbitration. If there is no winner, reg_we=0 and reg_wa/reg_wd hold their previous values.
- Simultaneous push and pop on the same cycle: count is unchanged. An incoming load is never written in its accept cycle; minimum latency from load accept to reg_we is 2 cycles.
- Scoreboard:
  - busy[iss_wa] is set on iss_valid (iss_wa!=0).
  - busy[x] is cleared in the cycle a load with wa==x is output on reg_we.
  - If set and clear hit the same register in the same cycle, set wins.
  - ALU writes never touch busy.
- Starvation: the queue may stall indefinitely under continuous ALU writes. Upstream guarantees gaps; the block does not age entries.
- Same-address ordering: an ALU write and a queued load may target the same register. The arbiter preserves arbitration order only; hazard avoidance is the issue stage's job via busy.

Optional Feature:
WB_BYPASS_EN
- Defined: adds inputs byp_ra1/byp_ra2 (AW) and outputs byp_hit1/byp_hit2 (1) and byp_d1/byp_d2 (DW).
  - byp_hitN = reg_we && reg_wa==byp_raN && byp_raN!=0.
  - byp_dN = reg_wd when hit, else 0.
  - This lets the decode stage forward data being written this cycle, since regfile reads are asynchronous and writes land at the edge.
- Undefined: these ports and the logic do not exist.

Decomposition:
- Shared package wb_pkg: AW, DW, REG_ZERO constant (5'd0), and a packed struct/typedef wb_req_t {wa, wd}.
- One natural sub-module: wb_lq_fifo (the parameterised load queue: push/pop, count, full/empty).
- Arbitration, the output register and the scoreboard stay in the top.

Test Plan:
- Reset mid-operation: queue holds 2 loads, busy[5]=1, assert rst -> same cycle reg_we=0, busy=0; after release lsu_ready=1.
- Lone load: iss r7 at t0; return r7=0xDEADBEEF accepted at t3 -> reg_we=1, wa=7, wd=0xDEADBEEF at t5; busy[7]=1 from t1, cleared after t5.
- Conflict: ALU r3=0x11 and load r4=0x22 accepted in the same cycle t -> t+1 writes r3=0x11, t+2 writes r4=0x22.
- Full queue: 4 consecutive ALU writes while loads return -> lsu_ready=0 after 2 accepts; no load lost; queued loads drain in FIFO order once the ALU idles.
- Zero register: ALU r0=0xFF and load r0=0xAA -> reg_we never asserts for them; busy[0] stays 0 after iss_wa=0.
- Set/clear collision: load r9 written while iss_valid r9 in the same cycle -> busy[9] remains 1; with WB_BYPASS_EN, byp_ra1=9 in the write cycle -> byp_hit1=1, byp_d1=load data.
